ad9783_dac_if: RTL and testbench

//  FPGA-side data/clock interface for an AD9783 dual 16-bit LVDS DAC. Registers two
//  16-bit channel words each clk_in cycle and sends them on one DDR LVDS bus:
//  DAC0 (port 1) in the high half-cycle, DAC1 (port 2) in the low half-cycle.

---
 rtl/ad9783_dac_if.sv | 71 +++++++
 tb/tb_ad9783_dac_if.sv | 106 ++++++++++
 2 files changed

// File: rtl/ad9783_dac_if.sv
// AD9783 DDR LVDS data/clock interface: two channel words per clk_in cycle, DAC0 high phase, DAC1 low phase.
// Latency 1 cycle to stage-1 register, data on bus from the next rising edge; no handshake, every cycle is a sample.
module ad9783_dac_if #(
    parameter int                 DATA_W     = 16,
    parameter bit                 OFFSET_BIN = 1'b0,
    parameter logic [DATA_W-1:0]  PN_SWAP    = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] DAC0_in,
    input  logic [DATA_W-1:0] DAC1_in,
    output logic              CLK_out_p,
    output logic              CLK_out_n,
    output logic              DCI_out_p,
    output logic              DCI_out_n,
    output logic [DATA_W-1:0] D_out_p,
    output logic [DATA_W-1:0] D_out_n
);

    localparam logic [DATA_W-1:0] MSB_MASK =
        OFFSET_BIN ? {1'b1, {(DATA_W-1){1'b0}}} : {DATA_W{1'b0}};

    logic [DATA_W-1:0] r0;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] ddr_d1;
    logic [DATA_W-1:0] ddr_d2;
    logic              dci_d1;
    logic              dci_d2;
    logic              clk_d1;
    logic              clk_d2;
    logic [DATA_W-1:0] ddr_mux;

    // Stage 1: sample and format
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r0 <= '0;
            r1 <= '0;
        end else begin
            r0 <= DAC0_in ^ MSB_MASK;
            r1 <= DAC1_in ^ MSB_MASK;
        end
    end

    // Stage 2: same-edge DDR register; the lane swap sits after it so reset yields 0^PN_SWAP
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ddr_d1 <= '0;
            ddr_d2 <= '0;
        end else begin
            ddr_d1 <= r0;
            ddr_d2 <= r1;
        end
    end

    // Strobe and forwarded clock ignore reset so the DAC DLL stays locked
    always_ff @(posedge clk_in) begin
        dci_d1 <= 1'b1;
        dci_d2 <= 1'b0;
        clk_d1 <= 1'b0;
        clk_d2 <= 1'b1;
    end

    assign ddr_mux   = clk_in ? ddr_d1 : ddr_d2;
    assign D_out_p   = ddr_mux ^ PN_SWAP;
    assign D_out_n   = ~D_out_p;
    assign DCI_out_p = clk_in ? dci_d1 : dci_d2;
    assign DCI_out_n = ~DCI_out_p;
    assign CLK_out_p = clk_in ? clk_d1 : clk_d2;
    assign CLK_out_n = ~CLK_out_p;

endmodule

// File: tb/tb_ad9783_dac_if.sv
// Randomized bench for ad9783_dac_if: default instance plus an offset-binary / lane-swapped instance.
module tb_ad9783_dac_if;

    localparam logic [15:0] PN_B = 16'h0001;

    logic        clk;
    logic        rst;
    logic [15:0] dac0;
    logic [15:0] dac1;

    logic        clk_p_a, clk_n_a, dci_p_a, dci_n_a;
    logic [15:0] d_p_a, d_n_a;
    logic        clk_p_b, clk_n_b, dci_p_b, dci_n_b;
    logic [15:0] d_p_b, d_n_b;

    int n_tests = 0;
    int n_fail  = 0;

    ad9783_dac_if dut_a (
        .clk_in(clk), .rst_in(rst), .DAC0_in(dac0), .DAC1_in(dac1),
        .CLK_out_p(clk_p_a), .CLK_out_n(clk_n_a),
        .DCI_out_p(dci_p_a), .DCI_out_n(dci_n_a),
        .D_out_p(d_p_a), .D_out_n(d_n_a)
    );

    ad9783_dac_if #(.DATA_W(16), .OFFSET_BIN(1'b1), .PN_SWAP(PN_B)) dut_b (
        .clk_in(clk), .rst_in(rst), .DAC0_in(dac0), .DAC1_in(dac1),
        .CLK_out_p(clk_p_b), .CLK_out_n(clk_n_b),
        .DCI_out_p(dci_p_b), .DCI_out_n(dci_n_b),
        .D_out_p(d_p_b), .D_out_n(d_n_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // Word on the bus for a sample, or the swap pattern alone when the sample was flushed by reset
    function automatic logic [15:0] bus_word(input logic [15:0] w, input bit offs,
                                             input logic [15:0] pn, input bit flushed);
        logic [15:0] f;
        f = offs ? {~w[15], w[14:0]} : w;
        return flushed ? pn : (f ^ pn);
    endfunction

    task automatic check_phase(input bit high, input logic [15:0] ea, input logic [15:0] eb);
        check(high ? "a_dp_hi" : "a_dp_lo", {16'h0, d_p_a}, {16'h0, ea});
        check(high ? "a_dn_hi" : "a_dn_lo", {16'h0, d_n_a}, {16'h0, ~ea});
        check(high ? "b_dp_hi" : "b_dp_lo", {16'h0, d_p_b}, {16'h0, eb});
        check(high ? "b_dn_hi" : "b_dn_lo", {16'h0, d_n_b}, {16'h0, ~eb});
        check("dci_a", {28'h0, dci_p_a, dci_n_a, clk_p_a, clk_n_a},
              {28'h0, high, ~high, ~high, high});
        check("dci_b", {28'h0, dci_p_b, dci_n_b, clk_p_b, clk_n_b},
              {28'h0, high, ~high, ~high, high});
    endtask

    initial begin
        logic [15:0] prev0, prev1;
        bit          prev_rst;
        logic [15:0] cur0, cur1;
        bit          cur_rst;
        bit          flushed;

        rst = 1'b1; dac0 = '0; dac1 = '0;
        prev0 = '0; prev1 = '0; prev_rst = 1'b1;

        for (int c = 0; c < 220; c++) begin
            if (c < 3) begin
                rst = 1'b1; dac0 = 16'($urandom); dac1 = 16'($urandom);
            end else if (c < 8) begin
                rst = 1'b0; dac0 = 16'hFFFF; dac1 = 16'h0000;
            end else if (c < 13) begin
                rst = 1'b0; dac0 = 16'h5555; dac1 = 16'hAAAA;
            end else if (c < 18) begin
                rst = 1'b0; dac0 = 16'h0000; dac1 = 16'h8000;
            end else if (c < 40) begin
                rst = (c == 28); dac0 = 16'(c); dac1 = ~16'(c);
            end else begin
                rst = ($urandom_range(0, 19) == 0); dac0 = 16'($urandom); dac1 = 16'($urandom);
            end
            cur_rst = rst; cur0 = dac0; cur1 = dac1;

            @(posedge clk);
            // Bus after this edge shows the previous edge's sample unless either edge saw reset
            flushed = cur_rst || prev_rst;
            #2;
            check_phase(1'b1, bus_word(prev0, 1'b0, 16'h0, flushed),
                              bus_word(prev0, 1'b1, PN_B, flushed));
            #5;
            check_phase(1'b0, bus_word(prev1, 1'b0, 16'h0, flushed),
                              bus_word(prev1, 1'b1, PN_B, flushed));

            prev0 = cur0; prev1 = cur1; prev_rst = cur_rst;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
